// File: rtl/wb_sram_pkg.sv
// ============================================================================
//  Module      : wb_sram_pkg
//  Description : Shared types and limits for the Wishbone-to-SRAM bridge.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_sram_pkg;

    // Upper bounds accepted for the latency parameters of the bridge
    localparam int RD_LATENCY_MAX = 4;
    localparam int WR_WAIT_MAX    = 3;

    // Latency counter width; must hold RD_LATENCY_MAX
    localparam int CNT_WIDTH      = 3;

    // Bridge transfer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_WAIT = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/wb_sram_bridge.sv
// ============================================================================
//  Module      : wb_sram_bridge
//  Description : Wishbone classic slave bridging one initiator to a
//                single-port synchronous SRAM. Address decode against a
//                base/mask (error on miss), byte write masks, configurable
//                read latency and write wait states, cycle-abort handling.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_sram_bridge
    import wb_sram_pkg::*;
#(
    parameter int                       WB_ADDR_WIDTH   = 32,
    parameter int                       DATA_WIDTH      = 32,
    parameter int                       SRAM_ADDR_WIDTH = 8,
    parameter int                       RD_LATENCY      = 1,
    parameter int                       WR_WAIT         = 0,
    parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR       = 32'h8000_0000,
    parameter logic [WB_ADDR_WIDTH-1:0] ADDR_MASK       = 32'hFFFF_0000
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_we_i,
    input  logic [DATA_WIDTH/8-1:0]    wbs_sel_i,
    input  logic [WB_ADDR_WIDTH-1:0]   wbs_adr_i,
    input  logic [DATA_WIDTH-1:0]      wbs_dat_i,
    output logic [DATA_WIDTH-1:0]      wbs_dat_o,
    output logic                       wbs_ack_o,
    output logic                       wbs_err_o,
    output logic                       sram_en_o,
    output logic                       sram_we_o,
    output logic [DATA_WIDTH/8-1:0]    sram_wmask_o,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_adr_o,
    output logic [DATA_WIDTH-1:0]      sram_dat_o,
    input  logic [DATA_WIDTH-1:0]      sram_dat_i,
    output logic                       busy_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int LSB       = $clog2(SEL_WIDTH);

    localparam logic [CNT_WIDTH-1:0] c_rd_lat  = CNT_WIDTH'(RD_LATENCY);
    localparam logic [CNT_WIDTH-1:0] c_wr_wait = CNT_WIDTH'(WR_WAIT);

    // Reject unsupported configurations at elaboration
    if ((RD_LATENCY < 1) || (RD_LATENCY > RD_LATENCY_MAX)) begin : g_bad_rd_latency
        $error("wb_sram_bridge: RD_LATENCY out of range 1..4");
    end
    if ((WR_WAIT < 0) || (WR_WAIT > WR_WAIT_MAX)) begin : g_bad_wr_wait
        $error("wb_sram_bridge: WR_WAIT out of range 0..3");
    end
    if ((DATA_WIDTH < 8) || ((DATA_WIDTH & (DATA_WIDTH - 1)) != 0)) begin : g_bad_data_width
        $error("wb_sram_bridge: DATA_WIDTH must be a power of two >= 8");
    end

    state_t                     state_q,  state_d;
    logic [CNT_WIDTH-1:0]       cnt_q,    cnt_d;
    logic                       ack_q,    ack_d;
    logic                       err_q,    err_d;
    logic                       en_q,     en_d;
    logic                       we_q,     we_d;
    logic [SEL_WIDTH-1:0]       wmask_q,  wmask_d;
    logic [SRAM_ADDR_WIDTH-1:0] adr_q,    adr_d;
    logic [DATA_WIDTH-1:0]      wdat_q,   wdat_d;
    logic [DATA_WIDTH-1:0]      rdat_q,   rdat_d;
    logic                       busy_q,   busy_d;

    logic                       w_req;
    logic                       w_hit;
    logic [SRAM_ADDR_WIDTH-1:0] w_idx;

    // A new request is only taken while no response is on the bus
    assign w_req = wbs_cyc_i & wbs_stb_i & ~ack_q & ~err_q;
    // Bits outside the mask and above the word index alias onto the same word
    assign w_hit = ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
    assign w_idx = wbs_adr_i[SRAM_ADDR_WIDTH+LSB-1:LSB];

    // Next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        en_d    = 1'b0;
        we_d    = we_q;
        wmask_d = wmask_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;

        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    if (!w_hit) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        adr_d = w_idx;
                        we_d  = wbs_we_i;
                        cnt_d = '0;
                        if (wbs_we_i) begin
                            // An all-zero select still takes the write latency
                            // but never touches the macro
                            wmask_d = wbs_sel_i;
                            wdat_d  = wbs_dat_i;
                            en_d    = |wbs_sel_i;
                            state_d = ST_WR_WAIT;
                        end else begin
                            wmask_d = '0;
                            en_d    = 1'b1;
                            state_d = ST_RD_WAIT;
                        end
                    end
                end
            end
            ST_WR_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == c_wr_wait) begin
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_RD_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == c_rd_lat) begin
                    rdat_d  = sram_dat_i;
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            wmask_q <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            en_q    <= en_d;
            we_q    <= we_d;
            wmask_q <= wmask_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            busy_q  <= busy_d;
        end
    end

    assign wbs_dat_o    = rdat_q;
    assign wbs_ack_o    = ack_q;
    assign wbs_err_o    = err_q;
    assign sram_en_o    = en_q;
    assign sram_we_o    = we_q;
    assign sram_wmask_o = wmask_q;
    assign sram_adr_o   = adr_q;
    assign sram_dat_o   = wdat_q;
    assign busy_o       = busy_q;

endmodule

`default_nettype wire
